// File: rtl/perf_counter_dump.sv
// Snapshot-and-stream readout engine for the pipeline performance counters.
// Captures all counters on a dump request, streams them plus an XOR trailer.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   cnt_in        flattened live counters, word i at [CNT_W*i +: CNT_W]
//   dump_req      start a dump (sampled only when idle)
//   out_valid     beat present      out_ready  consumer accepts beat
//   out_data      counter word or checksum
//   out_idx       word index, NUM_CNT on the trailer beat
//   out_last      trailer beat marker
//   busy          engine not idle   done       one-cycle completion pulse
module perf_counter_dump #(
    parameter int NUM_CNT = 25,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = $clog2(NUM_CNT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
    input  logic                     dump_req,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [CNT_W-1:0]         out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        TRAILER,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);
    localparam logic [IDX_W-1:0] TRL_IDX  = IDX_W'(NUM_CNT);

    state_t           state;
    logic [CNT_W-1:0] snap [NUM_CNT];
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [CNT_W-1:0] csum;
    logic [CNT_W-1:0] cur;
    logic [CNT_W-1:0] csum_nxt;

    assign idx_nxt  = idx + 1'b1;
    assign cur      = snap[idx];
    assign csum_nxt = csum ^ cur;

    // Outputs are registered; out_data/out_idx are preloaded with the
    // next beat on each handshake so they are stable during stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            csum      <= '0;
            for (int i = 0; i < NUM_CNT; i++) snap[i] <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (dump_req) begin
                        for (int i = 0; i < NUM_CNT; i++)
                            snap[i] <= cnt_in[CNT_W*i +: CNT_W];
                        idx       <= '0;
                        csum      <= '0;
                        state     <= STREAM;
                        out_valid <= 1'b1;
                        out_data  <= cnt_in[CNT_W-1:0];
                        out_idx   <= '0;
                        out_last  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        csum <= csum_nxt;
                        if (idx == LAST_IDX) begin
                            state    <= TRAILER;
                            out_data <= csum_nxt;
                            out_idx  <= TRL_IDX;
                            out_last <= 1'b1;
                        end else begin
                            idx      <= idx_nxt;
                            out_data <= snap[idx_nxt];
                            out_idx  <= idx_nxt;
                        end
                    end
                end
                TRAILER: begin
                    if (out_ready) begin
                        state     <= DONE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perf_counter_dump.sv
// Self-checking bench for perf_counter_dump.
// Table-driven dumps, hand-written corner sequences, random dumps vs model.
module tb_perf_counter_dump;

    localparam int NUM_CNT = 25;
    localparam int CNT_W   = 32;
    localparam int IDX_W   = $clog2(NUM_CNT + 1);

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CNT*CNT_W-1:0] cnt_in;
    logic                     dump_req;
    logic                     out_ready;
    logic                     out_valid;
    logic [CNT_W-1:0]         out_data;
    logic [IDX_W-1:0]         out_idx;
    logic                     out_last;
    logic                     busy;
    logic                     done;

    perf_counter_dump #(
        .NUM_CNT(NUM_CNT),
        .CNT_W  (CNT_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cnt_in   (cnt_in),
        .dump_req (dump_req),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // live = what the counter block drives; model = expected snapshot
    logic [31:0] live  [NUM_CNT];
    logic [31:0] model [NUM_CNT];
    logic [31:0] last_csum;

    task automatic pack();
        for (int i = 0; i < NUM_CNT; i++) cnt_in[CNT_W*i +: CNT_W] = live[i];
    endtask

    task automatic fill(input int kind);
        for (int i = 0; i < NUM_CNT; i++) begin
            case (kind)
                0:       live[i] = 32'(i + 1);
                1:       live[i] = 32'hFFFF_FFFF;
                default: live[i] = $urandom;
            endcase
        end
        pack();
    endtask

    // rmode: 0 ready always, 1 pattern 1,0,0,1, 2 random
    task automatic run_dump(input string nm, input int rmode,
                            input bit mutate, input bit hold);
        logic [31:0]      q_data[$];
        int               q_idx[$];
        bit               q_last[$];
        int               cyc, trl, stalls, ndone, done_at;
        bit               pstall;
        logic [31:0]      pd, x;
        logic [IDX_W-1:0] pi;
        int               nb;
        cyc = 0; trl = -1; stalls = 0; ndone = 0; done_at = -1;
        pstall = 0; pd = '0; pi = '0;
        for (int i = 0; i < NUM_CNT; i++) model[i] = live[i];
        x = '0;
        for (int i = 0; i < NUM_CNT; i++) x ^= model[i];
        @(negedge clk);
        dump_req = 1'b1;
        @(negedge clk);
        chk({nm, " first beat valid"}, 32'(out_valid), 1);
        chk({nm, " busy after req"}, 32'(busy), 1);
        if (!hold) dump_req = 1'b0;
        while (cyc < 400) begin
            if (mutate) begin
                for (int i = 0; i < NUM_CNT; i++) live[i] = live[i] + 1;
                pack();
            end
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid) begin
                if (pstall) begin
                    chk({nm, " stall data hold"}, out_data, pd);
                    chk({nm, " stall idx hold"}, 32'(out_idx), 32'(pi));
                end
                if (out_ready) begin
                    q_data.push_back(out_data);
                    q_idx.push_back(int'(out_idx));
                    q_last.push_back(out_last);
                    if (out_last && trl < 0) trl = cyc;
                end else begin
                    stalls++;
                end
                pstall = !out_ready;
                pd = out_data;
                pi = out_idx;
            end else begin
                pstall = 0;
            end
            if (done) begin
                ndone++;
                done_at = cyc;
            end
            if (trl >= 0 && cyc == trl + 2) break;
            @(negedge clk);
            cyc++;
        end
        chk({nm, " trailer seen"}, 32'(trl >= 0), 1);
        chk({nm, " beat count"}, 32'(q_data.size()), 32'(NUM_CNT + 1));
        nb = q_data.size() < NUM_CNT + 1 ? q_data.size() : NUM_CNT + 1;
        for (int i = 0; i < nb; i++) begin
            chk($sformatf("%s beat %0d data", nm, i), q_data[i],
                i < NUM_CNT ? model[i] : x);
            chk($sformatf("%s beat %0d idx", nm, i), 32'(q_idx[i]), 32'(i));
            chk($sformatf("%s beat %0d last", nm, i), 32'(q_last[i]),
                32'(i == NUM_CNT));
        end
        last_csum = nb == NUM_CNT + 1 ? q_data[NUM_CNT] : 32'hDEAD_BEEF;
        chk({nm, " duration"}, 32'(trl), 32'(NUM_CNT + stalls));
        chk({nm, " done pulses"}, 32'(ndone), 1);
        chk({nm, " done timing"}, 32'(done_at), 32'(trl + 1));
        chk({nm, " idle busy"}, 32'(busy), 0);
        chk({nm, " idle done"}, 32'(done), 0);
    endtask

    typedef struct {
        string       name;
        int          fill_kind;
        int          rmode;
        bit          mutate;
        logic [31:0] exp_csum;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{"basic",        0, 0, 1'b0, 32'h0000_0001};
        tbl[1] = '{"coherence",    0, 0, 1'b1, 32'h0000_0001};
        tbl[2] = '{"backpressure", 0, 1, 1'b0, 32'h0000_0001};
        tbl[3] = '{"all_ones",     1, 0, 1'b0, 32'hFFFF_FFFF};
        tbl[4] = '{"ones_bp",      1, 2, 1'b1, 32'hFFFF_FFFF};

        rst = 1'b1;
        dump_req = 1'b0;
        out_ready = 1'b0;
        cnt_in = '0;
        repeat (2) @(negedge clk);
        chk("reset valid", 32'(out_valid), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset last", 32'(out_last), 0);
        chk("reset idx", 32'(out_idx), 0);
        chk("reset data", out_data, 0);
        rst = 1'b0;

        for (int t = 0; t < 5; t++) begin
            fill(tbl[t].fill_kind);
            run_dump(tbl[t].name, tbl[t].rmode, tbl[t].mutate, 1'b0);
            chk({tbl[t].name, " csum"}, last_csum, tbl[t].exp_csum);
        end

        // Request held through a dump: restart only after IDLE.
        fill(0);
        run_dump("hold", 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("hold restart valid", 32'(out_valid), 1);
        chk("hold restart idx", 32'(out_idx), 0);
        chk("hold restart data", out_data, 32'd1);
        dump_req = 1'b0;
        out_ready = 1'b1;
        repeat (30) @(negedge clk);
        chk("hold drained busy", 32'(busy), 0);

        // Reset mid-dump at idx 10.
        fill(0);
        out_ready = 1'b1;
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        for (int c = 0; c < 40 && out_idx != 10; c++) @(negedge clk);
        chk("rst reached idx10", 32'(out_idx), 10);
        #2 rst = 1'b1;
        #1;
        chk("rst async valid", 32'(out_valid), 0);
        chk("rst async busy", 32'(busy), 0);
        chk("rst async done", 32'(done), 0);
        chk("rst async idx", 32'(out_idx), 0);
        chk("rst async data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst no trailer", 32'(out_valid), 0);
        chk("rst no done", 32'(done), 0);
        run_dump("after_rst", 0, 1'b0, 1'b0);
        chk("after_rst csum", last_csum, 32'h0000_0001);

        // Random contents, random backpressure, random counter motion.
        for (int r = 0; r < 6; r++) begin
            fill(2);
            run_dump($sformatf("rand%0d", r), 2, 1'($urandom_range(0, 1)),
                     1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
